// File: rtl/pwm_peak_ctrl.sv
// Peak-current-mode PWM controller.
// Runs bursts of fixed-frequency PWM periods. Each on-pulse ends when the
// decoded coil current reaches the setpoint (after blanking) or at the
// maximum on-time. A latched overcurrent fault overrides everything.
module pwm_peak_ctrl #(
   parameter int PERIOD = 16,
   parameter int BLANK  = 2,
   parameter int MAX_ON = 14,
   parameter int ILIMIT = 1845
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [11:0] iset,
   input  logic [15:0] burst_len,
   input  logic [11:0] iest_coil,
   output logic        pwm,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [7:0]  on_time
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_FAULT
   } state_t;

   localparam logic [7:0]         PCNT_LAST  = 8'(PERIOD - 1);
   localparam logic [7:0]         BLANK_C    = 8'(BLANK);
   localparam logic [7:0]         MAXON_LAST = 8'(MAX_ON - 1);
   localparam logic signed [12:0] ILIMIT_C   = 13'(ILIMIT);

   state_t      state_q, state_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic [15:0] prem_q, prem_d;
   logic [11:0] icoil_q, icoil_d;
   logic        armed_q, armed_d;
   logic        pwm_q, pwm_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
   logic [7:0]  on_time_q, on_time_d;

   logic signed [12:0] icoil_ext;
   logic signed [12:0] iset_ext;
   logic               over_limit;
   logic               at_setpoint;

   // The estimate arrives in inverted ADC format; flipping the low 11 bits
   // yields a two's-complement current value.
   assign icoil_d     = iest_coil ^ 12'h7FF;
   assign icoil_ext   = {icoil_q[11], icoil_q};
   assign iset_ext    = {1'b0, iset};
   assign over_limit  = (icoil_ext > ILIMIT_C);
   assign at_setpoint = (pcnt_q >= BLANK_C) && (icoil_ext >= iset_ext);

   // Next-state and registered-output decode; overcurrent outranks all else.
   always_comb begin
      state_d   = state_q;
      pcnt_d    = 8'd0;
      prem_d    = prem_q;
      armed_d   = armed_q | ~enable;
      done_d    = 1'b0;
      on_time_d = on_time_q;

      if (over_limit && (state_q != S_FAULT)) begin
         state_d = S_FAULT;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable && armed_q) begin
                  if (burst_len == 16'd0) begin
                     done_d  = 1'b1;
                     armed_d = 1'b0;
                  end else begin
                     state_d = S_ON;
                     prem_d  = burst_len;
                  end
               end
            end
            S_ON: begin
               if (!enable) begin
                  state_d = S_IDLE;
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
                  if (at_setpoint || (pcnt_q == MAXON_LAST)) begin
                     state_d   = S_OFF;
                     on_time_d = pcnt_q + 8'd1;
                  end
               end
            end
            S_OFF: begin
               if (!enable) begin
                  state_d = S_IDLE;
               end else if (pcnt_q == PCNT_LAST) begin
                  prem_d = prem_q - 16'd1;
                  if (prem_q == 16'd1) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     armed_d = 1'b0;
                  end else begin
                     state_d = S_ON;
                  end
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
               end
            end
            S_FAULT: begin
               if (!enable) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      pwm_d   = (state_d == S_ON);
      busy_d  = (state_d == S_ON) || (state_d == S_OFF);
      fault_d = (state_d == S_FAULT);
   end

   // State and output registers; reset drops pwm without waiting for clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pcnt_q    <= 8'd0;
         prem_q    <= 16'd0;
         icoil_q   <= 12'd0;
         armed_q   <= 1'b1;
         pwm_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
         on_time_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         prem_q    <= prem_d;
         icoil_q   <= icoil_d;
         armed_q   <= armed_d;
         pwm_q     <= pwm_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
         on_time_q <= on_time_d;
      end
   end

   assign pwm     = pwm_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign fault   = fault_q;
   assign on_time = on_time_q;

endmodule

// File: tb/tb_pwm_peak_ctrl.sv
// Testbench for pwm_peak_ctrl: directed scenarios followed by random
// stimulus, all compared cycle by cycle with a behavioural burst model.
module tb_pwm_peak_ctrl;

   localparam int PERIOD = 16;
   localparam int BLANK  = 2;
   localparam int MAX_ON = 14;
   localparam int ILIMIT = 1845;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [11:0] iset = 12'd0;
   logic [15:0] burst_len = 16'd0;
   logic [11:0] iest_coil;
   logic        pwm, busy, done, fault;
   logic [7:0]  on_time;

   int cur = 0;                     // coil current in signed DN
   assign iest_coil = 12'(cur) ^ 12'h7FF;

   pwm_peak_ctrl #(
      .PERIOD(PERIOD), .BLANK(BLANK), .MAX_ON(MAX_ON), .ILIMIT(ILIMIT)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .iset(iset),
      .burst_len(burst_len), .iest_coil(iest_coil), .pwm(pwm),
      .busy(busy), .done(done), .fault(fault), .on_time(on_time)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int hi_cnt = 0;

   // Behavioural model: mode 0 idle, 1 running a burst, 2 faulted.
   int m_mode, m_t, m_left, m_on_cnt, m_ontime, m_cur_q;
   bit m_high, m_done, m_armed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_t = 0; m_left = 0; m_on_cnt = 0; m_ontime = 0;
      m_cur_q = 0; m_high = 0; m_done = 0; m_armed = 1;
   endtask

   task automatic model_step();
      bit oc;
      oc = (m_cur_q > ILIMIT) && (m_mode != 2);
      m_done = 0;
      if (oc) begin
         m_mode = 2; m_high = 0;
      end else if (m_mode == 2) begin
         if (!enable) m_mode = 0;
      end else if (m_mode == 0) begin
         if (enable && m_armed) begin
            if (burst_len == 16'd0) begin
               m_done = 1; m_armed = 0;
            end else begin
               m_mode = 1; m_left = int'(burst_len); m_t = 0; m_high = 1; m_on_cnt = 1;
            end
         end
      end else begin
         if (!enable) begin
            m_mode = 0; m_high = 0;
         end else if (m_high) begin
            if ((m_t >= BLANK && m_cur_q >= int'(iset)) || m_t == MAX_ON - 1) begin
               m_high = 0; m_ontime = m_on_cnt;
            end else begin
               m_on_cnt++;
            end
            m_t++;
         end else if (m_t == PERIOD - 1) begin
            m_left--;
            if (m_left == 0) begin
               m_mode = 0; m_done = 1; m_armed = 0;
            end else begin
               m_t = 0; m_high = 1; m_on_cnt = 1;
            end
         end else begin
            m_t++;
         end
      end
      if (!enable) m_armed = 1;
      m_cur_q = cur;
   endtask

   // One clock: advance the model at the edge, compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("pwm", 32'(pwm), 32'(m_high));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_done));
      chk("fault", 32'(fault), 32'(m_mode == 2));
      chk("on_time", 32'(on_time), 32'(m_ontime));
      if (done === 1'b1) done_cnt++;
      if (pwm === 1'b1) hi_cnt++;
      $display("t=%0t en=%0d iset=%0d bl=%0d cur=%0d pwm=%0d busy=%0d done=%0d fault=%0d on_time=%0d",
               $time, enable, iset, burst_len, cur, pwm, busy, done, fault, on_time);
   endtask

   task automatic go_idle();
      enable = 1'b0; cur = 0;
      cycle(); cycle();
      done_cnt = 0; hi_cnt = 0;
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_pwm", 32'(pwm), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_on_time", 32'(on_time), 0);
      reset = 1'b1;
      go_idle();

      // Setpoint termination: ramp +100 DN per clock while pwm is high.
      iset = 12'd1025; burst_len = 16'd3; enable = 1'b1; cur = 0; n = 0;
      for (int i = 1; i <= 100; i++) begin
         cycle();
         if (m_high) cur += 100; else cur = 0;
         if (m_mode == 0) begin n = i; break; end
      end
      chk("sp_on_time", 32'(on_time), 12);
      chk("sp_done_cnt", 32'(done_cnt), 1);
      chk("sp_hi_cnt", 32'(hi_cnt), 36);
      chk("sp_len", 32'(n), 49);
      chk("sp_busy", 32'(busy), 0);
      go_idle();

      // Maximum duty: setpoint never reached.
      iset = 12'd2000; burst_len = 16'd2; cur = 205; enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (m_mode == 0) break;
      end
      chk("md_on_time", 32'(on_time), 14);
      chk("md_hi_cnt", 32'(hi_cnt), 28);
      chk("md_done_cnt", 32'(done_cnt), 1);
      go_idle();

      // Blanking: current already above setpoint at period start.
      iset = 12'd1025; burst_len = 16'd1; cur = 1500; enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (m_mode == 0) break;
      end
      chk("bl_on_time", 32'(on_time), 3);
      chk("bl_hi_cnt", 32'(hi_cnt), 3);
      go_idle();

      // Overcurrent mid-ON, latched until enable drops.
      iset = 12'd2000; burst_len = 16'd4; cur = 205; enable = 1'b1;
      repeat (5) cycle();
      cur = 1900;
      cycle(); cycle();
      chk("oc_fault", 32'(fault), 1);
      chk("oc_pwm", 32'(pwm), 0);
      cur = 205;
      repeat (4) cycle();
      chk("oc_hold", 32'(fault), 1);
      chk("oc_no_done", 32'(done_cnt), 0);
      enable = 1'b0;
      cycle();
      chk("oc_clear", 32'(fault), 0);
      go_idle();

      // Abort during period 2 of 5.
      iset = 12'd2000; burst_len = 16'd5; cur = 205; enable = 1'b1;
      repeat (20) cycle();
      enable = 1'b0;
      cycle();
      chk("ab_pwm", 32'(pwm), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_no_done", 32'(done_cnt), 0);
      go_idle();

      // Asynchronous reset mid-ON.
      burst_len = 16'd3; enable = 1'b1;
      repeat (4) cycle();
      chk("ar_pre_pwm", 32'(pwm), 1);
      #2 reset = 1'b0;
      #1;
      chk("ar_pwm", 32'(pwm), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_on_time", 32'(on_time), 0);
      model_reset();
      @(negedge clk);
      enable = 1'b0;
      reset = 1'b1;
      go_idle();

      // Zero-length burst: one done, no pwm, no repeat while enable held.
      burst_len = 16'd0; enable = 1'b1;
      repeat (6) cycle();
      chk("zl_done_cnt", 32'(done_cnt), 1);
      chk("zl_hi_cnt", 32'(hi_cnt), 0);
      go_idle();

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         if (m_mode == 0 && $urandom_range(0, 3) == 0) begin
            iset = 12'($urandom_range(0, 2047));
            burst_len = 16'($urandom_range(0, 3));
         end
         enable = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 39) == 0) cur = 1900;
         else cur = int'($urandom_range(0, 1800)) - 200;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
